bank_scan_sched: RTL and testbench
==================================

Name: bank_scan_sched

Overview:
- Scan scheduler for the margin-sampling datapath. It sequences reads over N_BANKS register banks at each sample address, walking the sample address from 0 in steps of INCR.
- For each sample address it issues one read per bank, bank 0 up to N_BANKS-1, then advances the address.
- Adds a start/done command interface, valid/ready backpressure toward the bank read mux, and abort, which a free-running enable-gated counter lacks.

Parameters:
- N_SAMPLES, 1024, number of sample addresses per scan; address range 0..N_SAMPLES-1.
- N_BANKS, 8, number of register banks read per sample address; must be at least 1.
- INCR, 1, address step applied after the last bank of each address; must be at least 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin scan; honoured only in IDLE.
- abort  in  1  terminate scan; honoured only in RUN.
- rd_valid  out  1  read request valid.
- rd_ready  in  1  downstream accepts request.
- rd_addr  out  ADDR_W  sample address; ADDR_W = max(1, clog2(N_SAMPLES)).
- rd_bank  out  BANK_W  bank index; BANK_W = max(1, clog2(N_BANKS)).
- rd_last  out  1  marks the final request of the scan.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a scan ends, whether completed or aborted.
- aborted  out  1  qualifies done; high for the same cycle only if the scan ended by abort.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM returns to IDLE.
  - rd_valid, rd_last, busy, done and aborted all go to 0.
  - rd_addr and rd_bank go to 0.
  - Reset overrides every other input, including mid-scan. No done pulse is produced by reset.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - rd_valid = 0.
  - On start=1: load addr=0 and bank=0, then go to RUN. rd_valid is 1 on the next cycle, so start-to-first-request latency is 1 cycle.
- RUN:
  - rd_valid = 1; rd_addr/rd_bank show the current position.
  - A handshake is rd_valid & rd_ready in the same cycle.
  - With no handshake, all outputs hold stable; values must not change while rd_ready=0.
  - On a handshake with bank < N_BANKS-1: bank increments by 1.
  - On a handshake with bank = N_BANKS-1: bank returns to 0 and addr becomes addr+INCR, computed at ADDR_W+1 bits.
  - rd_last = 1 when bank = N_BANKS-1 and addr+INCR >= N_SAMPLES (wide compare, no wrap).
  - A handshake while rd_last=1 goes to FIN.
  - If INCR does not divide N_SAMPLES, the last address is the largest multiple of INCR below N_SAMPLES. The address never wraps and never exceeds N_SAMPLES-1.
- Abort:
  - abort=1 in RUN goes to FIN with aborted set. This applies even if a handshake happens in the same cycle; that request counts as accepted, but nothing further is issued.
  - abort outside RUN is ignored.
- FIN:
  - done = 1 for exactly one cycle; aborted = 1 in that cycle if the scan was aborted.
  - rd_valid = 0. Next state is IDLE.
  - start is ignored in FIN; start in the cycle after done is accepted.
- start while busy (RUN or FIN) is ignored.
- Total requests per full scan = N_BANKS * ceil(N_SAMPLES / INCR).
- Minimum scan length with rd_ready held at 1: that request count, plus 1 cycle in IDLE, plus 1 cycle in FIN.
- N_BANKS = 1: rd_bank stays 0 and the address advances on every handshake.

Optional Feature:
- Macro: BANK_SCAN_STALL_CNT_EN.
- When defined:
  - Extra output port stall_cnt, 32 bits.
  - Counts cycles in RUN with rd_valid=1 and rd_ready=0.
  - Cleared on rst and on start acceptance; saturates at 0xFFFFFFFF; holds its value after done until the next start.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- N_SAMPLES=4, N_BANKS=2, INCR=1, rd_ready=1, start pulse:
  - Requests (addr,bank) = (0,0)(0,1)(1,0)(1,1)(2,0)(2,1)(3,0)(3,1).
  - rd_last only on (3,1).
  - done pulses once 1 cycle after that handshake, with aborted=0.
- Same config, rd_ready low for 3 cycles at (1,1):
  - rd_addr/rd_bank hold at (1,1) for those 3 cycles.
  - Sequence then resumes unchanged.
  - stall_cnt=3 at done (with macro defined).
- N_SAMPLES=10, N_BANKS=3, INCR=4:
  - Addresses 0, 4, 8 only; 9 requests.
  - rd_last at (8,2); no address >= 10 is ever issued.
- abort at request (2,0), with rd_ready=1, in the 4/2/1 config:
  - (2,0) is accepted; no further rd_valid.
  - done=1 with aborted=1 the next cycle; busy=0 after.
- rst=1 mid-scan at (1,0):
  - The next cycle shows IDLE with all outputs 0 and no done pulse.
  - A following start restarts at (0,0).
- start asserted every cycle:
  - Only one scan runs; starts during RUN and FIN are ignored.
  - A new scan begins the cycle after done.

Source files
------------

// File: rtl/bank_scan_sched.sv
// Scan scheduler: walks sample addresses 0..N_SAMPLES-1 in steps of INCR, reading every bank
// per address. Optional stall counter output enabled by defining BANK_SCAN_STALL_CNT_EN.
module bank_scan_sched #(
    parameter int unsigned N_SAMPLES = 1024,
    parameter int unsigned N_BANKS   = 8,
    parameter int unsigned INCR      = 1,
    localparam int unsigned ADDR_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int unsigned BANK_W   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [BANK_W-1:0] rd_bank,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef BANK_SCAN_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [BANK_W-1:0] BankMax = BANK_W'(N_BANKS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [31:0]       cur_sum;
    logic [31:0]       nxt_sum;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bank_d    = bank_q;
        aborted_d = 1'b0;
        // Wide sum so the end-of-scan test never sees a wrapped address.
        cur_sum   = 32'(addr_q) + INCR;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = '0;
                    bank_d  = '0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else if (rd_ready) begin
                    if (rd_last_q) begin
                        state_d = StFin;
                    end else if (bank_q == BankMax) begin
                        bank_d = '0;
                        addr_d = cur_sum[ADDR_W-1:0];
                    end else begin
                        bank_d = bank_q + BANK_W'(1);
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rd_valid_d = (state_d == StRun);
        busy_d     = (state_d == StRun);
        done_d     = (state_d == StFin);
        nxt_sum    = 32'(addr_d) + INCR;
        rd_last_d  = rd_valid_d && (32'(bank_d) == N_BANKS - 1) && (nxt_sum >= N_SAMPLES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            bank_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_addr  = addr_q;
    assign rd_bank  = bank_q;
    assign rd_last  = rd_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

`ifdef BANK_SCAN_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle && start) begin
            stall_cnt_d = '0;
        end else if (state_q == StRun && rd_valid_q && !rd_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bank_scan_sched.sv
// Scoreboard bench for bank_scan_sched: instance A (4/2/1) and instance B (10/3/4).
module tb_bank_scan_sched;

    typedef struct packed {
        logic [3:0] addr;
        logic [1:0] bank;
        logic       last;
    } req_t;

    logic       clk;
    logic       rst;
    logic       start_a, abort_a, rd_ready_a;
    logic       rd_valid_a, rd_last_a, busy_a, done_a, aborted_a;
    logic [1:0] rd_addr_a;
    logic [0:0] rd_bank_a;
    logic       start_b, abort_b, rd_ready_b;
    logic       rd_valid_b, rd_last_b, busy_b, done_b, aborted_b;
    logic [3:0] rd_addr_b;
    logic [1:0] rd_bank_b;
`ifdef BANK_SCAN_STALL_CNT_EN
    logic [31:0] stall_cnt_a, stall_cnt_b;
`endif

    int   checks = 0;
    int   errors = 0;
    req_t req_q_a[$];
    req_t req_q_b[$];
    logic done_q_a[$];
    logic done_q_b[$];
    int   exp_stall_a = 0;
    logic exp_done_a_next = 1'b0, prev_done_a = 1'b0;
    logic exp_done_b_next = 1'b0, prev_done_b = 1'b0;

    bank_scan_sched #(.N_SAMPLES(4), .N_BANKS(2), .INCR(1)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .abort    (abort_a),
        .rd_valid (rd_valid_a),
        .rd_ready (rd_ready_a),
        .rd_addr  (rd_addr_a),
        .rd_bank  (rd_bank_a),
        .rd_last  (rd_last_a),
        .busy     (busy_a),
        .done     (done_a),
        .aborted  (aborted_a)
`ifdef BANK_SCAN_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt_a)
`endif
    );

    bank_scan_sched #(.N_SAMPLES(10), .N_BANKS(3), .INCR(4)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .abort    (abort_b),
        .rd_valid (rd_valid_b),
        .rd_ready (rd_ready_b),
        .rd_addr  (rd_addr_b),
        .rd_bank  (rd_bank_b),
        .rd_last  (rd_last_b),
        .busy     (busy_b),
        .done     (done_b),
        .aborted  (aborted_b)
`ifdef BANK_SCAN_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_scan_a();
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 2; b++) begin
                req_q_a.push_back('{addr: 4'(a), bank: 2'(b), last: (a == 3 && b == 1)});
            end
        end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_a", 32'(done_a), 32'd1);
        tick(1);
    endtask

    // Monitor A: pops expected requests on handshakes, checks holds, done timing and idle gap.
    always @(negedge clk) begin
        if (rst) begin
            exp_done_a_next = 1'b0;
            prev_done_a     = 1'b0;
        end else begin
            if (exp_done_a_next || done_a) chk("done_timing_a", 32'(done_a), 32'(exp_done_a_next));
            if (done_a) begin
                if (done_q_a.size() == 0) begin
                    chk("unexpected_done_a", 32'(done_a), 32'd0);
                end else begin
                    chk("aborted_a", 32'(aborted_a), 32'(done_q_a.pop_front()));
                end
`ifdef BANK_SCAN_STALL_CNT_EN
                chk("stall_cnt_a", stall_cnt_a, 32'(exp_stall_a));
`endif
            end else if (aborted_a) begin
                chk("aborted_without_done_a", 32'(aborted_a), 32'd0);
            end
            if (prev_done_a) chk("idle_after_done_a", {30'd0, rd_valid_a, busy_a}, 32'd0);
            chk("busy_a", 32'(busy_a), 32'(rd_valid_a));
            exp_done_a_next = 1'b0;
            if (rd_valid_a) begin
                if (req_q_a.size() == 0) begin
                    chk("unexpected_req_a", 32'(rd_valid_a), 32'd0);
                end else begin
                    chk("addr_a", 32'(rd_addr_a), 32'(req_q_a[0].addr));
                    chk("bank_a", 32'(rd_bank_a), 32'(req_q_a[0].bank));
                    chk("last_a", 32'(rd_last_a), 32'(req_q_a[0].last));
                    if (rd_ready_a) begin
                        if (req_q_a[0].last) exp_done_a_next = 1'b1;
                        void'(req_q_a.pop_front());
                    end
                end
                if (abort_a) exp_done_a_next = 1'b1;
            end
            prev_done_a = done_a;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_done_b_next = 1'b0;
            prev_done_b     = 1'b0;
        end else begin
            if (exp_done_b_next || done_b) chk("done_timing_b", 32'(done_b), 32'(exp_done_b_next));
            if (done_b) begin
                if (done_q_b.size() == 0) begin
                    chk("unexpected_done_b", 32'(done_b), 32'd0);
                end else begin
                    chk("aborted_b", 32'(aborted_b), 32'(done_q_b.pop_front()));
                end
            end
            if (prev_done_b) chk("idle_after_done_b", {30'd0, rd_valid_b, busy_b}, 32'd0);
            chk("busy_b", 32'(busy_b), 32'(rd_valid_b));
            exp_done_b_next = 1'b0;
            if (rd_valid_b) begin
                chk("addr_range_b", 32'(rd_addr_b < 4'd10), 32'd1);
                if (req_q_b.size() == 0) begin
                    chk("unexpected_req_b", 32'(rd_valid_b), 32'd0);
                end else begin
                    chk("addr_b", 32'(rd_addr_b), 32'(req_q_b[0].addr));
                    chk("bank_b", 32'(rd_bank_b), 32'(req_q_b[0].bank));
                    chk("last_b", 32'(rd_last_b), 32'(req_q_b[0].last));
                    if (rd_ready_b) begin
                        if (req_q_b[0].last) exp_done_b_next = 1'b1;
                        void'(req_q_b.pop_front());
                    end
                end
            end
            prev_done_b = done_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start_a    = 1'b0;
        abort_a    = 1'b0;
        rd_ready_a = 1'b1;
        start_b    = 1'b0;
        abort_b    = 1'b0;
        rd_ready_b = 1'b1;
        tick(2);
        chk("reset_outs_a", {25'd0, rd_valid_a, rd_addr_a, rd_bank_a, rd_last_a, busy_a, done_a,
                             aborted_a}, 32'd0);
        chk("reset_outs_b", {22'd0, rd_valid_b, rd_addr_b, rd_bank_b, rd_last_b, busy_b, done_b,
                             aborted_b}, 32'd0);
`ifdef BANK_SCAN_STALL_CNT_EN
        chk("reset_stall_a", stall_cnt_a, 32'd0);
`endif
        rst = 1'b0;
        tick(2);

        // Full scan, ready always high.
        exp_stall_a = 0;
        push_scan_a();
        done_q_a.push_back(1'b0);
        pulse_start_a();
        wait_done_a(50);
        chk("reqq_empty_full_a", 32'(req_q_a.size()), 32'd0);

        // Three stall cycles while (1,1) is presented.
        exp_stall_a = 3;
        push_scan_a();
        done_q_a.push_back(1'b0);
        pulse_start_a();
        tick(3);
        rd_ready_a = 1'b0;
        tick(3);
        rd_ready_a = 1'b1;
        wait_done_a(50);
        chk("reqq_empty_stall_a", 32'(req_q_a.size()), 32'd0);

        // Abort together with the handshake of (2,0).
        exp_stall_a = 0;
        req_q_a.push_back('{addr: 4'd0, bank: 2'd0, last: 1'b0});
        req_q_a.push_back('{addr: 4'd0, bank: 2'd1, last: 1'b0});
        req_q_a.push_back('{addr: 4'd1, bank: 2'd0, last: 1'b0});
        req_q_a.push_back('{addr: 4'd1, bank: 2'd1, last: 1'b0});
        req_q_a.push_back('{addr: 4'd2, bank: 2'd0, last: 1'b0});
        done_q_a.push_back(1'b1);
        pulse_start_a();
        tick(4);
        abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        wait_done_a(20);
        tick(3);
        chk("busy_after_abort_a", {30'd0, busy_a, rd_valid_a}, 32'd0);
        chk("reqq_empty_abort_a", 32'(req_q_a.size()), 32'd0);

        // Reset while (1,0) is presented, then restart from (0,0).
        req_q_a.push_back('{addr: 4'd0, bank: 2'd0, last: 1'b0});
        req_q_a.push_back('{addr: 4'd0, bank: 2'd1, last: 1'b0});
        req_q_a.push_back('{addr: 4'd1, bank: 2'd0, last: 1'b0});
        pulse_start_a();
        tick(2);
        chk("pre_reset_addr_a", {30'd0, rd_addr_a}, 32'd1);
        rst        = 1'b1;
        rd_ready_a = 1'b0;
        tick(1);
        rst        = 1'b0;
        rd_ready_a = 1'b1;
        req_q_a.delete();
        chk("midscan_reset_outs_a", {25'd0, rd_valid_a, rd_addr_a, rd_bank_a, rd_last_a, busy_a,
                                     done_a, aborted_a}, 32'd0);
        tick(3);
        push_scan_a();
        done_q_a.push_back(1'b0);
        pulse_start_a();
        wait_done_a(50);
        chk("reqq_empty_restart_a", 32'(req_q_a.size()), 32'd0);

        // start held high: second scan begins only after the idle cycle following done.
        push_scan_a();
        push_scan_a();
        done_q_a.push_back(1'b0);
        done_q_a.push_back(1'b0);
        start_a = 1'b1;
        tick(11);
        start_a = 1'b0;
        wait_done_a(50);
        chk("reqq_empty_held_a", 32'(req_q_a.size()), 32'd0);
        chk("doneq_empty_a", 32'(done_q_a.size()), 32'd0);

        // Instance B: non-dividing step, ready low every third cycle.
        for (int a = 0; a < 10; a += 4) begin
            for (int b = 0; b < 3; b++) begin
                req_q_b.push_back('{addr: 4'(a), bank: 2'(b), last: (a == 8 && b == 2)});
            end
        end
        done_q_b.push_back(1'b0);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int i = 0; i < 60 && !done_b; i++) begin
            rd_ready_b = (i % 3 != 1);
            tick(1);
        end
        rd_ready_b = 1'b1;
        chk("timeout_b", 32'(done_b), 32'd1);
        tick(3);
        chk("reqq_empty_b", 32'(req_q_b.size()), 32'd0);
        chk("doneq_empty_b", 32'(done_q_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
